// File: rtl/mc_control_fsm_pkg.sv
// Encodings shared by the multi-cycle MIPS control FSM and its helpers.
package mc_control_fsm_pkg;

   // Instruction opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ALUOp
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALUSrcB
   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PCSource
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_R_WB     = 4'd7,
      S_ADDI_WB  = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_HALT     = 4'd11
   } state_e;

   // Moore control word. 'fetch' marks FETCH so IRWrite/PCWrite can be
   // qualified by the live MemReady.
   typedef struct packed {
      logic       mem_req;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       fetch;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
   } ctrl_t;

   function automatic ctrl_t ctrl_of(state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req   = 1'b1;
            c.mem_read  = 1'b1;
            c.fetch     = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALUOP_ADD;
            c.pc_source = PCSRC_ALU;
         end
         S_DECODE:   c.alu_src_b = SRCB_IMM_SH2;
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: begin
            c.mem_req  = 1'b1;
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_req   = 1'b1;
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_REGB;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_ADDI_WB:  c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_REGB;
            c.alu_op        = ALUOP_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_control_fsm_perf_counters.sv
// Cycle and retired-instruction counters; both wrap and freeze while halted.
module mc_control_fsm_perf_counters
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             Clock_i,
   input  logic             Reset_n_i,
   input  logic             run_i,
   input  logic             retire_i,
   output logic [CNT_W-1:0] CycleCount_o,
   output logic [CNT_W-1:0] InstrCount_o
);

   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instr_q, instr_d;

   // Next counts: advance only while the FSM is running.
   always_comb begin
      cycle_d = cycle_q;
      instr_d = instr_q;
      if (run_i) begin
         cycle_d = cycle_q + CNT_W'(1);
         if (retire_i) instr_d = instr_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge Clock_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         cycle_q <= cycle_d;
         instr_q <= instr_d;
      end
   end

   assign CycleCount_o = cycle_q;
   assign InstrCount_o = instr_q;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: sequences one instruction over 3-5 states,
// handshakes the unified memory port with a bounded wait, counts cycles/retires.
module mc_control_fsm
   import mc_control_fsm_pkg::*;
#(
   parameter int unsigned OPCODE_W    = 6,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter bit          HAS_ADDI    = 1'b1
) (
   input  logic                Clock_i,
   input  logic                Reset_n_i,
   input  logic [OPCODE_W-1:0] Opcode_i,
   input  logic                Zero_i,
   input  logic                MemReady_i,
   output logic                MemReq_o,
   output logic                MemRead_o,
   output logic                MemWrite_o,
   output logic                IorD_o,
   output logic                IRWrite_o,
   output logic                PCWrite_o,
   output logic                PCWriteCond_o,
   output logic [1:0]          PCSource_o,
   output logic [1:0]          ALUOp_o,
   output logic                ALUSrcA_o,
   output logic [1:0]          ALUSrcB_o,
   output logic                RegWrite_o,
   output logic                RegDst_o,
   output logic                MemToReg_o,
   output logic                Illegal_o,
   output logic                BusError_o,
   output logic [CNT_W-1:0]    CycleCount_o,
   output logic [CNT_W-1:0]    InstrCount_o
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_e            state_q, state_d;
   ctrl_t             ctrl_q, ctrl_live;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              illegal_q, buserr_q;
   logic              mem_state, timeout, retire, illegal_set;
   logic              op_rt, op_lw, op_sw, op_beq, op_j, op_addi;

   // Zero is consumed by the datapath together with PCWriteCond.
   logic unused_zero;
   assign unused_zero = Zero_i;

   assign op_rt   = (Opcode_i == OPCODE_W'(OP_RTYPE));
   assign op_lw   = (Opcode_i == OPCODE_W'(OP_LW));
   assign op_sw   = (Opcode_i == OPCODE_W'(OP_SW));
   assign op_beq  = (Opcode_i == OPCODE_W'(OP_BEQ));
   assign op_j    = (Opcode_i == OPCODE_W'(OP_J));
   assign op_addi = HAS_ADDI && (Opcode_i == OPCODE_W'(OP_ADDI));

   // MemReady on the last allowed cycle still completes, so timeout needs !MemReady.
   assign mem_state = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
   assign timeout   = mem_state && !MemReady_i && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   // Next-state, retire and illegal-opcode decode.
   always_comb begin
      state_d     = state_q;
      retire      = 1'b0;
      illegal_set = 1'b0;
      case (state_q)
         S_FETCH:  if (MemReady_i) state_d = S_DECODE;
         S_DECODE: begin
            if (op_rt)                           state_d = S_EXEC;
            else if (op_lw || op_sw || op_addi)  state_d = S_MEM_ADDR;
            else if (op_beq)                     state_d = S_BRANCH;
            else if (op_j)                       state_d = S_JUMP;
            else begin
               illegal_set = 1'b1;
               state_d     = S_FETCH;
            end
         end
         S_MEM_ADDR: begin
            if (op_lw)        state_d = S_MEM_RD;
            else if (op_sw)   state_d = S_MEM_WR;
            else if (op_addi) state_d = S_ADDI_WB;
            else              state_d = S_FETCH;
         end
         S_MEM_RD: if (MemReady_i) state_d = S_MEM_WB;
         S_MEM_WR: begin
            if (MemReady_i) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC: state_d = S_R_WB;
         S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
      if (timeout) state_d = S_HALT;
   end

   // Wait counter restarts on every state change, counts not-ready cycles otherwise.
   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q)            wait_d = '0;
      else if (mem_state && !MemReady_i) wait_d = wait_q + WAIT_W'(1);
   end

   // FSM state, registered Moore outputs and sticky error flags.
   always_ff @(posedge Clock_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         state_q   <= S_FETCH;
         ctrl_q    <= ctrl_of(S_FETCH);
         wait_q    <= '0;
         illegal_q <= 1'b0;
         buserr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_of(state_d);
         wait_q  <= wait_d;
         if (illegal_set) illegal_q <= 1'b1;
         if (timeout)     buserr_q  <= 1'b1;
      end
   end

   // ctrl_q holds the FETCH word through reset so FETCH drives on release;
   // gating with Reset_n keeps every strobe low while reset is asserted.
   assign ctrl_live = Reset_n_i ? ctrl_q : '0;

   assign MemReq_o      = ctrl_live.mem_req;
   assign MemRead_o     = ctrl_live.mem_read;
   assign MemWrite_o    = ctrl_live.mem_write;
   assign IorD_o        = ctrl_live.iord;
   assign IRWrite_o     = ctrl_live.fetch & MemReady_i;
   assign PCWrite_o     = ctrl_live.pc_write | (ctrl_live.fetch & MemReady_i);
   assign PCWriteCond_o = ctrl_live.pc_write_cond;
   assign PCSource_o    = ctrl_live.pc_source;
   assign ALUOp_o       = ctrl_live.alu_op;
   assign ALUSrcA_o     = ctrl_live.alu_src_a;
   assign ALUSrcB_o     = ctrl_live.alu_src_b;
   assign RegWrite_o    = ctrl_live.reg_write;
   assign RegDst_o      = ctrl_live.reg_dst;
   assign MemToReg_o    = ctrl_live.mem_to_reg;
   assign Illegal_o     = illegal_q;
   assign BusError_o    = buserr_q;

   mc_control_fsm_perf_counters #(.CNT_W(CNT_W)) u_perf (
      .Clock_i      (Clock_i),
      .Reset_n_i    (Reset_n_i),
      .run_i        (state_q != S_HALT),
      .retire_i     (retire),
      .CycleCount_o (CycleCount_o),
      .InstrCount_o (InstrCount_o)
   );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level reference model (step lists per
// opcode, expected control word per step) driven with random memory waits.
module tb_mc_control_fsm;

   localparam int TB_CNT_W = 4;
   localparam int TB_TO    = 4;

   // Instruction steps as seen from the outside.
   localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
   localparam int P_EX = 6, P_RWB = 7, P_AWB = 8, P_BR = 9, P_J = 10;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

   logic Clock = 1'b0, Reset_n = 1'b0;
   logic [5:0] Opcode = '0;
   logic Zero = 1'b0, MemReady = 1'b0;
   logic MemReq, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
   logic [1:0] PCSource, ALUOp, ALUSrcB;
   logic ALUSrcA, RegWrite, RegDst, MemToReg, Illegal, BusError;
   logic [TB_CNT_W-1:0] CycleCount, InstrCount;
   logic [16:0] dut_cw;

   int n_tests = 0, n_fail = 0;
   int exp_cyc = 0, exp_ins = 0;
   bit exp_ill = 1'b0, exp_bus = 1'b0;

   mc_control_fsm #(.OPCODE_W(6), .CNT_W(TB_CNT_W), .MEM_TIMEOUT(TB_TO), .HAS_ADDI(1'b1)) dut (
      .Clock_i(Clock), .Reset_n_i(Reset_n), .Opcode_i(Opcode), .Zero_i(Zero),
      .MemReady_i(MemReady), .MemReq_o(MemReq), .MemRead_o(MemRead),
      .MemWrite_o(MemWrite), .IorD_o(IorD), .IRWrite_o(IRWrite), .PCWrite_o(PCWrite),
      .PCWriteCond_o(PCWriteCond), .PCSource_o(PCSource), .ALUOp_o(ALUOp),
      .ALUSrcA_o(ALUSrcA), .ALUSrcB_o(ALUSrcB), .RegWrite_o(RegWrite),
      .RegDst_o(RegDst), .MemToReg_o(MemToReg), .Illegal_o(Illegal),
      .BusError_o(BusError), .CycleCount_o(CycleCount), .InstrCount_o(InstrCount)
   );

   assign dut_cw = {MemReq, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
                    PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, MemToReg};

   always #5 Clock = ~Clock;

   function automatic int seq_len(logic [5:0] op);
      case (op)
         LW:            return 5;
         SW, RT, ADDI:  return 4;
         BEQ, JMP:      return 3;
         default:       return 2;
      endcase
   endfunction

   function automatic int seq_step(logic [5:0] op, int i);
      if (i == 0) return P_F;
      if (i == 1) return P_D;
      case (op)
         LW:      return (i == 2) ? P_MA : (i == 3) ? P_MR : P_MWB;
         SW:      return (i == 2) ? P_MA : P_MW;
         RT:      return (i == 2) ? P_EX : P_RWB;
         ADDI:    return (i == 2) ? P_MA : P_AWB;
         BEQ:     return P_BR;
         default: return P_J;
      endcase
   endfunction

   // Expected control word for a step, in dut_cw bit order.
   function automatic logic [16:0] exp_cw(int st, logic rdy);
      logic mreq, mrd, mwr, iord, irw, pcw, pwc, srca, rw, rdst, m2r;
      logic [1:0] pcs, aop, srcb;
      {mreq, mrd, mwr, iord, irw, pcw, pwc, srca, rw, rdst, m2r} = '0;
      pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
      case (st)
         P_F:   begin mreq = 1; mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
         P_D:   srcb = 2'b11;
         P_MA:  begin srca = 1; srcb = 2'b10; end
         P_MR:  begin mreq = 1; mrd = 1; iord = 1; end
         P_MWB: begin rw = 1; m2r = 1; end
         P_MW:  begin mreq = 1; mwr = 1; iord = 1; end
         P_EX:  begin srca = 1; aop = 2'b10; end
         P_RWB: begin rw = 1; rdst = 1; end
         P_AWB: rw = 1;
         P_BR:  begin srca = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
         P_J:   begin pcw = 1; pcs = 2'b10; end
         default: ;
      endcase
      return {mreq, mrd, mwr, iord, irw, pcw, pwc, pcs, aop, srca, srcb, rw, rdst, m2r};
   endfunction

   function automatic logic [5:0] rand_op();
      case ($urandom_range(0, 6))
         0: return LW;
         1: return SW;
         2: return RT;
         3: return BEQ;
         4: return JMP;
         5: return ADDI;
         default: return 6'($urandom);
      endcase
   endfunction

   // Run one instruction; a wait >= TB_TO means memory never answers (timeout).
   // Entered and left one time unit after a rising edge.
   task automatic exec_instr(input logic [5:0] op, input int wf, input int wm, input logic z);
      int st, w, nc;
      bit mem;
      Opcode = op;
      Zero   = z;
      for (int i = 0; i < seq_len(op); i++) begin
         st  = seq_step(op, i);
         mem = (st == P_F) || (st == P_MR) || (st == P_MW);
         w   = !mem ? 0 : (st == P_F) ? wf : wm;
         nc  = (w >= TB_TO) ? TB_TO : w + 1;
         for (int c = 0; c < nc; c++) begin
            MemReady = mem ? (c == w) : 1'($urandom);
            @(negedge Clock);
            n_tests++;
            if (dut_cw !== exp_cw(st, MemReady) || CycleCount !== TB_CNT_W'(exp_cyc) ||
                InstrCount !== TB_CNT_W'(exp_ins) || Illegal !== exp_ill || BusError !== exp_bus) begin
               n_fail++;
               $display("FAIL instr op=%b step=%0d: cw=%b want %b cyc=%0d want %0d ins=%0d want %0d ill=%b want %b bus=%b want %b",
                        op, st, dut_cw, exp_cw(st, MemReady), CycleCount, TB_CNT_W'(exp_cyc),
                        InstrCount, TB_CNT_W'(exp_ins), Illegal, exp_ill, BusError, exp_bus);
            end
            @(posedge Clock); #1;
            exp_cyc++;
         end
         if (w >= TB_TO) begin
            exp_bus = 1'b1;
            return;
         end
         if (st inside {P_MWB, P_MW, P_RWB, P_AWB, P_BR, P_J}) exp_ins++;
      end
      if (seq_len(op) == 2) exp_ill = 1'b1;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      exp_cyc = 0; exp_ins = 0; exp_ill = 1'b0; exp_bus = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; MemReady = 1'b1; Opcode = LW;
      @(posedge Clock); #1;
      n_tests++;
      if (dut_cw !== 17'd0 || CycleCount !== '0 || InstrCount !== '0 || Illegal !== 1'b0 || BusError !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: cw=%b cyc=%0d ins=%0d ill=%b bus=%b, want all zero",
                  dut_cw, CycleCount, InstrCount, Illegal, BusError);
      end
      Reset_n = 1'b1;
      exp_cyc = 0; exp_ins = 0; exp_ill = 1'b0; exp_bus = 1'b0;
      #1;
      n_tests++;
      if (dut_cw !== exp_cw(P_F, 1'b1)) begin
         n_fail++;
         $display("FAIL reset_release: cw=%b want %b", dut_cw, exp_cw(P_F, 1'b1));
      end
      @(posedge Clock); #1;
      exp_cyc++;
   endtask

   task automatic test_lw();
      do_reset();
      exec_instr(LW, 0, 0, 1'b0);
      n_tests++;
      if (InstrCount !== TB_CNT_W'(1)) begin
         n_fail++;
         $display("FAIL lw_retire: InstrCount=%0d want 1", InstrCount);
      end
      exec_instr(LW, 3, 3, 1'b0);   // MemReady on the last allowed cycle
   endtask

   task automatic test_sw_wait();
      exec_instr(SW, 0, 3, 1'b0);
      exec_instr(SW, 1, 0, 1'b1);
   endtask

   task automatic test_beq_jump_addi();
      exec_instr(BEQ, 0, 0, 1'b1);
      exec_instr(BEQ, 0, 0, 1'b0);
      exec_instr(JMP, 2, 0, 1'b0);
      exec_instr(ADDI, 0, 0, 1'b0);
      n_tests++;
      if (InstrCount !== TB_CNT_W'(exp_ins)) begin
         n_fail++;
         $display("FAIL branch_retires: InstrCount=%0d want %0d", InstrCount, TB_CNT_W'(exp_ins));
      end
   endtask

   task automatic test_illegal();
      exec_instr(6'b111111, 0, 0, 1'b0);
      n_tests++;
      if (Illegal !== 1'b1 || InstrCount !== TB_CNT_W'(exp_ins)) begin
         n_fail++;
         $display("FAIL illegal_flag: Illegal=%b want 1 ins=%0d want %0d", Illegal, InstrCount, TB_CNT_W'(exp_ins));
      end
      exec_instr(RT, 0, 0, 1'b0);   // Illegal stays set
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++)
         exec_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
   endtask

   task automatic test_reset_mid();
      Opcode = LW;
      for (int k = 0; k < 3; k++) begin
         MemReady = 1'b1;
         @(posedge Clock); #1;
      end
      MemReady = 1'b0;
      @(negedge Clock);
      n_tests++;
      if (dut_cw !== exp_cw(P_MR, 1'b0)) begin
         n_fail++;
         $display("FAIL mid_in_memrd: cw=%b want %b", dut_cw, exp_cw(P_MR, 1'b0));
      end
      #1 Reset_n = 1'b0;
      #1;
      n_tests++;
      if (dut_cw !== 17'd0 || CycleCount !== '0 || InstrCount !== '0 || Illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_async: cw=%b cyc=%0d ins=%0d ill=%b, want all zero",
                  dut_cw, CycleCount, InstrCount, Illegal);
      end
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      exp_cyc = 0; exp_ins = 0; exp_ill = 1'b0; exp_bus = 1'b0;
      exec_instr(JMP, 0, 0, 1'b0);
   endtask

   task automatic test_wrap();
      do_reset();
      for (int n = 0; n < 16; n++) exec_instr(RT, $urandom_range(0, 3), 0, 1'b0);
      n_tests++;
      if (InstrCount !== '0) begin
         n_fail++;
         $display("FAIL instr_wrap: InstrCount=%0d want 0", InstrCount);
      end
   endtask

   task automatic test_timeout();
      for (int t = 0; t < 2; t++) begin
         do_reset();
         if (t == 0) exec_instr(LW, TB_TO, 0, 1'b0);   // FETCH never answered
         else        exec_instr(SW, 0, TB_TO, 1'b0);   // MEM_WR never answered
         for (int k = 0; k < 3; k++) begin
            MemReady = 1'($urandom);
            @(negedge Clock);
            n_tests++;
            if (dut_cw !== 17'd0 || BusError !== exp_bus || CycleCount !== TB_CNT_W'(exp_cyc) ||
                InstrCount !== TB_CNT_W'(exp_ins)) begin
               n_fail++;
               $display("FAIL halt_%0d: cw=%b want 0 bus=%b want %b cyc=%0d want %0d ins=%0d want %0d",
                        t, dut_cw, BusError, exp_bus, CycleCount, TB_CNT_W'(exp_cyc),
                        InstrCount, TB_CNT_W'(exp_ins));
            end
            @(posedge Clock); #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_wait();
      test_beq_jump_addi();
      test_illegal();
      test_random();
      test_reset_mid();
      test_wrap();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
